// File: rtl/rggen_axi4lite_master_bridge_if.sv
// rtl/rggen_axi4lite_master_bridge_if.sv - AXI4-Lite channel bundle between the bridge and the register adapter
// Signal names keep the bridge-side i_/o_ orientation so the master modport reads like the port list.
interface rggen_axi4lite_master_bridge_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int ID_WIDTH      = 0
);
  localparam int IDW = (ID_WIDTH == 0) ? 1 : ID_WIDTH;

  logic                     o_awvalid;
  logic                     i_awready;
  logic [IDW-1:0]           o_awid;
  logic [ADDRESS_WIDTH-1:0] o_awaddr;
  logic [2:0]               o_awprot;
  logic                     o_wvalid;
  logic                     i_wready;
  logic [BUS_WIDTH-1:0]     o_wdata;
  logic [BUS_WIDTH/8-1:0]   o_wstrb;
  logic                     i_bvalid;
  logic                     o_bready;
  logic [IDW-1:0]           i_bid;
  logic [1:0]               i_bresp;
  logic                     o_arvalid;
  logic                     i_arready;
  logic [IDW-1:0]           o_arid;
  logic [ADDRESS_WIDTH-1:0] o_araddr;
  logic [2:0]               o_arprot;
  logic                     i_rvalid;
  logic                     o_rready;
  logic [IDW-1:0]           i_rid;
  logic [1:0]               i_rresp;
  logic [BUS_WIDTH-1:0]     i_rdata;

  modport master (
    output o_awvalid, o_awid, o_awaddr, o_awprot, o_wvalid, o_wdata, o_wstrb, o_bready,
           o_arvalid, o_arid, o_araddr, o_arprot, o_rready,
    input  i_awready, i_wready, i_bvalid, i_bid, i_bresp, i_arready,
           i_rvalid, i_rid, i_rresp, i_rdata
  );

  modport slave (
    input  o_awvalid, o_awid, o_awaddr, o_awprot, o_wvalid, o_wdata, o_wstrb, o_bready,
           o_arvalid, o_arid, o_araddr, o_arprot, o_rready,
    output i_awready, i_wready, i_bvalid, i_bid, i_bresp, i_arready,
           i_rvalid, i_rid, i_rresp, i_rdata
  );
endinterface

// File: rtl/rggen_axi4lite_master_bridge.sv
// rtl/rggen_axi4lite_master_bridge.sv - single-outstanding AXI4-Lite master driven by a command/response stream
// Every bus-facing output is a flop or a pure state decode; no input reaches an output combinationally.
module rggen_axi4lite_master_bridge #(
  parameter int          ADDRESS_WIDTH = 8,
  parameter int          BUS_WIDTH     = 32,
  parameter int          ID_WIDTH      = 0,
  parameter int          ID_VALUE      = 0,
  parameter logic [2:0]  AXPROT        = 3'b000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic                     o_rsp_write,
  output logic [1:0]               o_rsp_status,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  rggen_axi4lite_master_bridge_if.master axi
);
  localparam int IDW = (ID_WIDTH == 0) ? 1 : ID_WIDTH;

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP} state_e;

  state_e                   state_q;
  logic                     write_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]     data_q;
  logic [BUS_WIDTH/8-1:0]   strobe_q;
  logic                     awvalid_q;
  logic                     wvalid_q;
  logic                     aw_done_q;
  logic                     w_done_q;
  logic [1:0]               status_q;
  logic [BUS_WIDTH-1:0]     read_data_q;

  logic aw_done_d;
  logic w_done_d;
  logic unused_ids;

  // A handshake in the current cycle counts as done, so simultaneous AW/W completion leaves WRITE at once.
  assign aw_done_d  = aw_done_q | (awvalid_q & axi.i_awready);
  assign w_done_d   = w_done_q  | (wvalid_q  & axi.i_wready);
  assign unused_ids = ^{axi.i_bid, axi.i_rid};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      address_q   <= '0;
      data_q      <= '0;
      strobe_q    <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      status_q    <= 2'b00;
      read_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_cmd_valid) begin
            write_q   <= i_cmd_write;
            address_q <= i_cmd_address;
            data_q    <= i_cmd_write_data;
            strobe_q  <= i_cmd_strobe;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (i_cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WRITE;
            end else begin
              state_q   <= READ;
            end
          end
        end
        WRITE: begin
          if (axi.i_awready) awvalid_q <= 1'b0;
          if (axi.i_wready)  wvalid_q  <= 1'b0;
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) state_q <= WAIT_B;
        end
        WAIT_B: begin
          if (axi.i_bvalid) begin
            status_q    <= axi.i_bresp;
            read_data_q <= '0;
            state_q     <= RESP;
          end
        end
        READ: begin
          if (axi.i_arready) state_q <= WAIT_R;
        end
        WAIT_R: begin
          if (axi.i_rvalid) begin
            status_q    <= axi.i_rresp;
            read_data_q <= axi.i_rdata;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (i_rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready     = (state_q == IDLE);
  assign o_rsp_valid     = (state_q == RESP);
  assign o_rsp_write     = write_q;
  assign o_rsp_status    = status_q;
  assign o_rsp_read_data = read_data_q;

  assign axi.o_awvalid = awvalid_q;
  assign axi.o_awid    = (ID_WIDTH == 0) ? '0 : IDW'(ID_VALUE);
  assign axi.o_awaddr  = address_q;
  assign axi.o_awprot  = AXPROT;
  assign axi.o_wvalid  = wvalid_q;
  assign axi.o_wdata   = data_q;
  assign axi.o_wstrb   = strobe_q;
  assign axi.o_bready  = (state_q == WAIT_B);
  assign axi.o_arvalid = (state_q == READ);
  assign axi.o_arid    = (ID_WIDTH == 0) ? '0 : IDW'(ID_VALUE);
  assign axi.o_araddr  = address_q;
  assign axi.o_arprot  = AXPROT;
  assign axi.o_rready  = (state_q == WAIT_R);
endmodule

// File: tb/tb_rggen_axi4lite_master_bridge.sv
// tb/tb_rggen_axi4lite_master_bridge.sv - directed self-checking bench for the AXI4-Lite master bridge
module tb_rggen_axi4lite_master_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_address = '0;
  logic [31:0] cmd_write_data = '0;
  logic [3:0]  cmd_strobe = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_read_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rggen_axi4lite_master_bridge_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .ID_WIDTH(0)) bus ();

  rggen_axi4lite_master_bridge dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_write      (cmd_write),
    .i_cmd_address    (cmd_address),
    .i_cmd_write_data (cmd_write_data),
    .i_cmd_strobe     (cmd_strobe),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_write      (rsp_write),
    .o_rsp_status     (rsp_status),
    .o_rsp_read_data  (rsp_read_data),
    .axi              (bus)
  );

  // Bus monitor: handshake log, B count and valid-withdrawal / payload-stability checks.
  int          cyc = 0;
  int          n_acc = 0;
  int          n_rsp = 0;
  int          n_b = 0;
  int          viol = 0;
  int          acc_cyc [16];
  int          rsp_cyc [16];
  logic [31:0] rsp_dat [16];
  logic        rsp_wr  [16];
  logic        p_rst = 1'b0, p_aw = 1'b0, p_awr = 1'b0, p_w = 1'b0, p_wr = 1'b0, p_ar = 1'b0, p_arr = 1'b0;
  logic [7:0]  p_awaddr = '0, p_araddr = '0;
  logic [31:0] p_wdata = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (cmd_valid && cmd_ready && n_acc < 16) begin
        acc_cyc[n_acc] = cyc;
        n_acc = n_acc + 1;
      end
      if (rsp_valid && rsp_ready && n_rsp < 16) begin
        rsp_cyc[n_rsp] = cyc;
        rsp_dat[n_rsp] = rsp_read_data;
        rsp_wr[n_rsp]  = rsp_write;
        n_rsp = n_rsp + 1;
      end
      if (bus.i_bvalid && bus.o_bready) n_b = n_b + 1;
    end
    if (rst_n && p_rst) begin
      if (p_aw && !p_awr && !(bus.o_awvalid && bus.o_awaddr == p_awaddr)) viol = viol + 1;
      if (p_w  && !p_wr  && !(bus.o_wvalid  && bus.o_wdata  == p_wdata))  viol = viol + 1;
      if (p_ar && !p_arr && !(bus.o_arvalid && bus.o_araddr == p_araddr)) viol = viol + 1;
    end
    p_rst = rst_n;
    p_aw = bus.o_awvalid; p_awr = bus.i_awready; p_awaddr = bus.o_awaddr;
    p_w  = bus.o_wvalid;  p_wr  = bus.i_wready;  p_wdata  = bus.o_wdata;
    p_ar = bus.o_arvalid; p_arr = bus.i_arready; p_araddr = bus.o_araddr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic any_valid_low(input string tag);
    chk(tag, {bus.o_awvalid, bus.o_wvalid, bus.o_arvalid}, 3'b000);
  endtask

  int a0, r0, b0;

  initial begin
    bus.i_awready = 0; bus.i_wready = 0; bus.i_bvalid = 0; bus.i_bid = 0; bus.i_bresp = 0;
    bus.i_arready = 0; bus.i_rvalid = 0; bus.i_rid = 0; bus.i_rresp = 0; bus.i_rdata = 0;

    // Reset values
    step(2);
    chk("rst_cmd_ready", cmd_ready, 1);
    any_valid_low("rst_valids");
    chk("rst_bready", bus.o_bready, 0);
    chk("rst_rready", bus.o_rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_status", rsp_status, 0);
    chk("rst_rdata", rsp_read_data, 0);
    chk("awid_tied", bus.o_awid, 0);
    rst_n = 1;

    // Zero-wait write
    cmd_valid = 1; cmd_write = 1; cmd_address = 8'h10; cmd_write_data = 32'hDEADBEEF; cmd_strobe = 4'hF;
    bus.i_awready = 1; bus.i_wready = 1; bus.i_bvalid = 1; bus.i_bresp = 2'b00;
    b0 = n_b;
    step(1);
    cmd_valid = 0;
    chk("w1_awvalid", bus.o_awvalid, 1);
    chk("w1_wvalid", bus.o_wvalid, 1);
    chk("w1_awaddr", bus.o_awaddr, 8'h10);
    chk("w1_wdata", bus.o_wdata, 32'hDEADBEEF);
    chk("w1_wstrb", bus.o_wstrb, 4'hF);
    chk("w1_cmd_ready", cmd_ready, 0);
    step(1);
    chk("w1_aw_w_low", {bus.o_awvalid, bus.o_wvalid}, 2'b00);
    chk("w1_bready", bus.o_bready, 1);
    step(1);
    bus.i_bvalid = 0;
    chk("w1_rsp_valid", rsp_valid, 1);
    chk("w1_status", rsp_status, 2'b00);
    chk("w1_rdata", rsp_read_data, 0);
    chk("w1_rsp_write", rsp_write, 1);
    chk("w1_bcount", n_b - b0, 1);
    rsp_ready = 1;
    step(1);
    rsp_ready = 0;
    chk("w1_idle_ready", cmd_ready, 1);
    chk("w1_rsp_dropped", rsp_valid, 0);

    // Write with AW delayed three cycles, W immediate
    cmd_valid = 1; cmd_write = 1; cmd_address = 8'h10; cmd_write_data = 32'hDEADBEEF; cmd_strobe = 4'hF;
    bus.i_awready = 0; bus.i_wready = 1; bus.i_bresp = 2'b01;
    b0 = n_b;
    step(1);
    cmd_valid = 0;
    chk("w2_both_valid", {bus.o_awvalid, bus.o_wvalid}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("w2_aw_held", bus.o_awvalid, 1);
      chk("w2_w_dropped", bus.o_wvalid, 0);
      chk("w2_addr_stable", bus.o_awaddr, 8'h10);
    end
    chk("w2_no_bready_yet", bus.o_bready, 0);
    bus.i_awready = 1;
    step(1);
    chk("w2_aw_dropped", bus.o_awvalid, 0);
    chk("w2_bready", bus.o_bready, 1);
    bus.i_bvalid = 1;
    step(1);
    bus.i_bvalid = 0;
    chk("w2_rsp_valid", rsp_valid, 1);
    chk("w2_status", rsp_status, 2'b01);
    chk("w2_one_b", n_b - b0, 1);
    rsp_ready = 1;
    step(1);
    rsp_ready = 0;

    // Read with SLVERR, then response held back five cycles
    cmd_valid = 1; cmd_write = 0; cmd_address = 8'h04;
    bus.i_arready = 1; bus.i_rvalid = 1; bus.i_rresp = 2'b10; bus.i_rdata = 32'h12345678;
    step(1);
    cmd_valid = 0;
    chk("r1_arvalid", bus.o_arvalid, 1);
    chk("r1_araddr", bus.o_araddr, 8'h04);
    step(1);
    chk("r1_ar_dropped", bus.o_arvalid, 0);
    chk("r1_rready", bus.o_rready, 1);
    step(1);
    bus.i_rvalid = 0; bus.i_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      chk("r1_hold_valid", rsp_valid, 1);
      chk("r1_hold_data", rsp_read_data, 32'h12345678);
      chk("r1_hold_status", rsp_status, 2'b10);
      chk("r1_hold_write", rsp_write, 0);
      chk("r1_hold_cmd_ready", cmd_ready, 0);
      any_valid_low("r1_hold_no_valid");
      step(1);
    end
    rsp_ready = 1;
    step(1);
    rsp_ready = 0;
    chk("r1_idle", cmd_ready, 1);

    // Reset during WAIT_B, then a fresh read
    cmd_valid = 1; cmd_write = 1; cmd_address = 8'h20; cmd_write_data = 32'h0BADF00D; cmd_strobe = 4'h1;
    bus.i_awready = 1; bus.i_wready = 1; bus.i_bvalid = 0;
    step(1);
    cmd_valid = 0;
    step(1);
    chk("rb_in_wait_b", bus.o_bready, 1);
    rst_n = 0;
    step(1);
    rst_n = 1;
    chk("rb_bready", bus.o_bready, 0);
    any_valid_low("rb_valids");
    chk("rb_rsp_valid", rsp_valid, 0);
    chk("rb_cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = 0; cmd_address = 8'h08;
    bus.i_arready = 1; bus.i_rvalid = 1; bus.i_rresp = 2'b00; bus.i_rdata = 32'hCAFEF00D;
    step(1);
    cmd_valid = 0;
    step(2);
    chk("rb_read_valid", rsp_valid, 1);
    chk("rb_read_data", rsp_read_data, 32'hCAFEF00D);
    chk("rb_read_status", rsp_status, 2'b00);
    rsp_ready = 1;
    step(1);
    rsp_ready = 0;

    // Back-to-back: write then read with cmd_valid held high
    a0 = n_acc; r0 = n_rsp;
    cmd_valid = 1; cmd_write = 1; cmd_address = 8'h30; cmd_write_data = 32'hA5A5A5A5; cmd_strobe = 4'h3;
    bus.i_awready = 1; bus.i_wready = 1; bus.i_bvalid = 1; bus.i_bresp = 2'b00;
    bus.i_arready = 1; bus.i_rvalid = 1; bus.i_rresp = 2'b00; bus.i_rdata = 32'h55AA55AA;
    rsp_ready = 1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (n_acc >= a0 + 1) begin
        cmd_write = 0; cmd_address = 8'h34;
      end
      if (n_rsp >= r0 + 2) break;
    end
    cmd_valid = 0; rsp_ready = 0;
    bus.i_bvalid = 0; bus.i_rvalid = 0;
    chk("bb_accepts", n_acc - a0, 2);
    chk("bb_responses", n_rsp - r0, 2);
    if (n_acc - a0 == 2 && n_rsp - r0 == 2) begin
      chk("bb_latency", rsp_cyc[r0] - acc_cyc[a0], 3);
      chk("bb_next_accept", acc_cyc[a0 + 1] - rsp_cyc[r0], 1);
      chk("bb_first_write", rsp_wr[r0], 1);
      chk("bb_first_data", rsp_dat[r0], 0);
      chk("bb_second_write", rsp_wr[r0 + 1], 0);
      chk("bb_second_data", rsp_dat[r0 + 1], 32'h55AA55AA);
    end
    step(2);
    chk("protocol_violations", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
